// File: rtl/bit_scan_encoder.sv
// Serialises the set-bit positions of a WIDTH-bit vector, one index per beat, LSB- or MSB-first.
// Latency: vector accepted at edge N shows its first beat in cycle N+1; k set bits -> k beats, zero vector -> 1 beat.
// Backpressure: with out_ready low the current beat holds stable; in_ready rises only in IDLE or on the last beat's transfer.
module bit_scan_encoder #(
   parameter int WIDTH     = 16,
   parameter bit MSB_FIRST = 1'b0,
   localparam int POS_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_bits,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [POS_W-1:0] out_pos,
   output logic             out_last,
   output logic             out_empty
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] pend, pend_nxt;
   logic             zero_vec, zero_vec_nxt;

   logic [POS_W-1:0] sel_pos;
   logic [WIDTH-1:0] sel_oh;
   logic             multi_set;

   // Priority-encode pend; the loop direction makes the winning bit the last one visited.
   always_comb begin
      sel_pos = '0;
      sel_oh  = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (pend[i]) begin
               sel_pos = POS_W'(i);
               sel_oh  = WIDTH'(1) << i;
            end
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend[i]) begin
               sel_pos = POS_W'(i);
               sel_oh  = WIDTH'(1) << i;
            end
         end
      end
   end

   // x & (x-1) is non-zero exactly when two or more bits are set.
   assign multi_set = |(pend & (pend - WIDTH'(1)));
   assign out_pos   = sel_pos;
   assign out_last  = ~multi_set;
   assign out_empty = zero_vec & out_valid;

   // State register with synchronous reset; a reset mid-scan drops the vector in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         pend     <= '0;
         zero_vec <= 1'b0;
      end else begin
         state    <= state_nxt;
         pend     <= pend_nxt;
         zero_vec <= zero_vec_nxt;
      end
   end

   // Next-state and handshake outputs; the final beat's transfer re-opens the input for a zero-gap reload.
   always_comb begin
      state_nxt    = state;
      pend_nxt     = pend;
      zero_vec_nxt = zero_vec;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               pend_nxt     = in_bits;
               zero_vec_nxt = (in_bits == '0);
               state_nxt    = SCAN;
            end
         end
         SCAN: begin
            out_valid = 1'b1;
            if (out_ready) begin
               pend_nxt = pend & ~sel_oh;
               if (out_last) begin
                  in_ready     = 1'b1;
                  zero_vec_nxt = 1'b0;
                  state_nxt    = IDLE;
                  if (in_valid) begin
                     pend_nxt     = in_bits;
                     zero_vec_nxt = (in_bits == '0);
                     state_nxt    = SCAN;
                  end
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // Handshakes are forced idle for as long as reset is asserted.
      if (reset) begin
         in_ready  = 1'b0;
         out_valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Bench for bit_scan_encoder: three instances (16-bit LSB-first, 16-bit MSB-first, 5-bit LSB-first).
// Directed cycle tables for reset, ordering, backpressure, zero vectors, back-to-back and mid-scan reset.
// Randomised traffic on all three instances compared against a queue-based beat model.
module tb_bit_scan_encoder;

   logic clk;
   logic rst16, rst5;
   logic [2:0] iv, ir, ov, ordy, ol, oe;
   logic [2:0][15:0] ib;
   logic [2:0][3:0]  pos;
   logic [2:0] pos_c;

   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bit_scan_encoder #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_a (
      .clk(clk), .reset(rst16), .in_valid(iv[0]), .in_ready(ir[0]), .in_bits(ib[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_pos(pos[0]), .out_last(ol[0]), .out_empty(oe[0]));

   bit_scan_encoder #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_b (
      .clk(clk), .reset(rst16), .in_valid(iv[1]), .in_ready(ir[1]), .in_bits(ib[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_pos(pos[1]), .out_last(ol[1]), .out_empty(oe[1]));

   bit_scan_encoder #(.WIDTH(5), .MSB_FIRST(1'b0)) dut_c (
      .clk(clk), .reset(rst5), .in_valid(iv[2]), .in_ready(ir[2]), .in_bits(ib[2][4:0]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .out_pos(pos_c), .out_last(ol[2]), .out_empty(oe[2]));

   assign pos[2] = {1'b0, pos_c};

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // ---------------- directed cycle tables ----------------
   typedef struct {
      bit        iv;
      logic [15:0] ib;
      bit        ordy;
      bit        e_ir;
      bit        e_ov;
      int        e_pos;
      bit        e_last;
      bit        e_empty;
   } row_t;

   function automatic row_t mk(bit v, logic [15:0] b, bit r, bit eir, bit eov, int ep, bit el, bit ee);
      row_t x;
      x.iv = v; x.ib = b; x.ordy = r; x.e_ir = eir; x.e_ov = eov;
      x.e_pos = ep; x.e_last = el; x.e_empty = ee;
      return x;
   endfunction

   // Called just after a rising edge: drive, check at the falling edge, advance one cycle.
   task automatic apply_row(input int d, input row_t r, input string tag);
      iv[d] = r.iv; ib[d] = r.ib; ordy[d] = r.ordy;
      @(negedge clk);
      chk({tag, ".in_ready"}, int'(ir[d]), int'(r.e_ir));
      chk({tag, ".out_valid"}, int'(ov[d]), int'(r.e_ov));
      if (r.e_ov) begin
         chk({tag, ".pos"}, int'(pos[d]), r.e_pos);
         chk({tag, ".last"}, int'(ol[d]), int'(r.e_last));
         chk({tag, ".empty"}, int'(oe[d]), int'(r.e_empty));
      end
      @(posedge clk); #1;
   endtask

   // ---------------- reference model ----------------
   typedef struct { int p; bit last; bit empty; } beat_t;
   beat_t exp_q[3][$];
   bit    held[3];
   beat_t hv[3];
   bit    rnd_on = 1'b0;
   int    wid[3] = '{16, 16, 5};
   bit    msb[3] = '{1'b0, 1'b1, 1'b0};

   // Expected beats: list the set-bit indices in emission order, flag the final one.
   function automatic void model(input int d, input logic [15:0] bits);
      int idx[$];
      for (int i = 0; i < wid[d]; i++)
         if (bits[i]) begin
            if (msb[d]) idx.push_front(i);
            else        idx.push_back(i);
         end
      if (idx.size() == 0) exp_q[d].push_back('{0, 1'b1, 1'b1});
      else
         for (int k = 0; k < idx.size(); k++)
            exp_q[d].push_back('{idx[k], (k == idx.size() - 1), 1'b0});
   endfunction

   always @(negedge clk) begin
      if (rnd_on) begin
         for (int d = 0; d < 3; d++) begin
            if (ov[d]) begin
               if (held[d]) begin
                  chk($sformatf("rnd%0d.hold_pos", d), int'(pos[d]), hv[d].p);
                  chk($sformatf("rnd%0d.hold_last", d), int'(ol[d]), int'(hv[d].last));
                  chk($sformatf("rnd%0d.hold_empty", d), int'(oe[d]), int'(hv[d].empty));
               end
               if (ordy[d]) begin
                  if (exp_q[d].size() == 0) chk($sformatf("rnd%0d.extra_beat", d), 1, 0);
                  else begin
                     beat_t e;
                     e = exp_q[d].pop_front();
                     chk($sformatf("rnd%0d.pos", d), int'(pos[d]), e.p);
                     chk($sformatf("rnd%0d.last", d), int'(ol[d]), int'(e.last));
                     chk($sformatf("rnd%0d.empty", d), int'(oe[d]), int'(e.empty));
                  end
                  held[d] = 1'b0;
               end else begin
                  held[d] = 1'b1;
                  hv[d]   = '{int'(pos[d]), ol[d], oe[d]};
               end
            end else if (held[d]) begin
               chk($sformatf("rnd%0d.valid_dropped", d), 0, 1);
               held[d] = 1'b0;
            end
            if (iv[d] && ir[d]) model(d, ib[d]);
         end
      end
   end

   row_t tab_a[11];
   row_t tab_b[7];
   row_t tab_c1[3];
   row_t tab_c2[3];

   initial begin
      // LSB-first 8421, zero vector, then back-to-back 0001 / 8000.
      tab_a[0]  = mk(1, 16'h8421, 1, 1, 0, 0, 0, 0);
      tab_a[1]  = mk(0, 16'h0000, 1, 0, 1, 0, 0, 0);
      tab_a[2]  = mk(0, 16'h0000, 1, 0, 1, 5, 0, 0);
      tab_a[3]  = mk(0, 16'h0000, 1, 0, 1, 10, 0, 0);
      tab_a[4]  = mk(0, 16'h0000, 1, 1, 1, 15, 1, 0);
      tab_a[5]  = mk(1, 16'h0000, 1, 1, 0, 0, 0, 0);
      tab_a[6]  = mk(0, 16'h0000, 1, 1, 1, 0, 1, 1);
      tab_a[7]  = mk(1, 16'h0001, 1, 1, 0, 0, 0, 0);
      tab_a[8]  = mk(1, 16'h8000, 1, 1, 1, 0, 1, 0);
      tab_a[9]  = mk(0, 16'h0000, 1, 1, 1, 15, 1, 0);
      tab_a[10] = mk(0, 16'h0000, 1, 1, 0, 0, 0, 0);
      // MSB-first 0006 with three stalled cycles.
      tab_b[0] = mk(1, 16'h0006, 0, 1, 0, 0, 0, 0);
      tab_b[1] = mk(0, 16'h0000, 0, 0, 1, 2, 0, 0);
      tab_b[2] = mk(0, 16'h0000, 0, 0, 1, 2, 0, 0);
      tab_b[3] = mk(0, 16'h0000, 0, 0, 1, 2, 0, 0);
      tab_b[4] = mk(0, 16'h0000, 1, 0, 1, 2, 0, 0);
      tab_b[5] = mk(0, 16'h0000, 1, 1, 1, 1, 1, 0);
      tab_b[6] = mk(0, 16'h0000, 1, 1, 0, 0, 0, 0);
      // 5-bit: 11111 for two beats, then reset, then 10000.
      tab_c1[0] = mk(1, 16'h001F, 1, 1, 0, 0, 0, 0);
      tab_c1[1] = mk(0, 16'h0000, 1, 0, 1, 0, 0, 0);
      tab_c1[2] = mk(0, 16'h0000, 1, 0, 1, 1, 0, 0);
      tab_c2[0] = mk(1, 16'h0010, 1, 1, 0, 0, 0, 0);
      tab_c2[1] = mk(0, 16'h0000, 1, 1, 1, 4, 1, 0);
      tab_c2[2] = mk(0, 16'h0000, 1, 1, 0, 0, 0, 0);

      iv = '0; ordy = '0; ib = '0;
      rst16 = 1'b1; rst5 = 1'b1;
      for (int d = 0; d < 3; d++) held[d] = 1'b0;

      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset%0d.in_ready", d), int'(ir[d]), 0);
            chk($sformatf("reset%0d.out_valid", d), int'(ov[d]), 0);
         end
      end
      @(posedge clk); #1;
      rst16 = 1'b0; rst5 = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("idle%0d.in_ready", d), int'(ir[d]), 1);
         chk($sformatf("idle%0d.out_valid", d), int'(ov[d]), 0);
      end
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) apply_row(0, tab_a[i], $sformatf("lsb_row%0d", i));
      for (int i = 0; i < 7; i++)  apply_row(1, tab_b[i], $sformatf("msb_row%0d", i));
      for (int i = 0; i < 3; i++)  apply_row(2, tab_c1[i], $sformatf("w5a_row%0d", i));

      // Reset lands while the third beat (pos 2) is being presented.
      iv[2] = 1'b0; rst5 = 1'b1;
      @(negedge clk);
      chk("w5_reset.out_valid", int'(ov[2]), 0);
      chk("w5_reset.in_ready", int'(ir[2]), 0);
      @(posedge clk); #1;
      rst5 = 1'b0;
      for (int i = 0; i < 3; i++)  apply_row(2, tab_c2[i], $sformatf("w5b_row%0d", i));

      // Randomised traffic on all three instances.
      rnd_on = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int d = 0; d < 3; d++) begin
            logic [15:0] mask, b;
            int mode;
            mask = (wid[d] == 16) ? 16'hFFFF : 16'h001F;
            mode = $urandom_range(0, 3);
            if (mode == 0)      b = 16'h0000;
            else if (mode == 1) b = 16'h0001 << $urandom_range(0, wid[d] - 1);
            else                b = 16'($urandom) & mask;
            iv[d]   = ($urandom_range(0, 99) < 60);
            ib[d]   = b;
            ordy[d] = ($urandom_range(0, 99) < 70);
         end
         @(posedge clk); #1;
      end

      iv = '0; ordy = 3'b111;
      for (int k = 0; k < 100 && ov != 3'b000; k++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      rnd_on = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("drain%0d.out_valid", d), int'(ov[d]), 0);
         chk($sformatf("drain%0d.beats_left", d), exp_q[d].size(), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
